ftoi: RTL and testbench

Pipelined IEEE-754 single-precision to signed 32-bit integer converter in the FPU datapath. It is the inverse of the integer-to-float unit and feeds the `fcvt.w.s`-class instructions. Throughput is one conversion per cycle, latency is fixed at 3 cycles, and there is no backpressure. Rounding mode is selected at elaboration time; out-of-range inputs saturate and raise a flag.

---
 rtl/fpu_pkg.sv | 54 +++++
 rtl/ftoi_align.sv | 38 +++
 rtl/ftoi.sv | 147 ++++++++++++++
 tb/tb_ftoi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, integer limits,
// operand classes and the classifier used by the float-to-int converter.
package fpu_pkg;

  localparam int FP_EXP_W  = 32'd8;
  localparam int FP_FRAC_W = 32'd23;

  localparam logic [FP_EXP_W-1:0] FP_BIAS  = 8'd127;
  localparam logic [31:0]         INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0]         INT_MIN  = 32'h8000_0000;

  // 158 is the first exponent with |x| >= 2^31; 126 is the first with |x| >= 0.5
  localparam logic [FP_EXP_W-1:0] EXP_SAT  = FP_BIAS + 8'd31;
  localparam logic [FP_EXP_W-1:0] EXP_HALF = FP_BIAS - 8'd1;
  localparam logic [FP_EXP_W-1:0] EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_NORM    = 3'd1,
    CLS_SAT_POS = 3'd2,
    CLS_SAT_NEG = 3'd3,
    CLS_NAN     = 3'd4
  } fp_class_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp_class_t fp_classify(input fp32_t f);
    fp_class_t cls;
    if (f.exp == 8'd0) begin
      cls = CLS_ZERO;
    end else if (f.exp == EXP_MAX) begin
      if (f.frac != 23'd0) begin
        cls = CLS_NAN;
      end else begin
        cls = f.sign ? CLS_SAT_NEG : CLS_SAT_POS;
      end
    end else if (f.exp >= EXP_SAT) begin
      // -2^31 is the one representable value at or above the saturation exponent
      if (f.sign && (f.exp == EXP_SAT) && (f.frac == 23'd0)) begin
        cls = CLS_NORM;
      end else begin
        cls = f.sign ? CLS_SAT_NEG : CLS_SAT_POS;
      end
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ftoi_align.sv
// Combinational aligner: shifts the 24-bit significand into a 32-bit integer
// magnitude and extracts the guard and sticky bits for rounding.
module ftoi_align
  import fpu_pkg::*;
(
  input  logic [23:0]         mant,
  input  logic [FP_EXP_W-1:0] expn,
  output logic [31:0]         mag,
  output logic                guard,
  output logic                sticky
);

  logic [7:0]  shamt_s;
  logic [55:0] shifted_s;

  // {m, 32'b0} >> (158 - e): integer part lands in [55:24], guard at [23], sticky below
  always_comb begin
    shamt_s   = 8'd0;
    shifted_s = 56'd0;
    mag       = 32'd0;
    guard     = 1'b0;
    sticky    = 1'b0;
    if (expn >= EXP_HALF) begin
      if (expn >= EXP_SAT) begin
        shamt_s = 8'd0;
      end else begin
        shamt_s = EXP_SAT - expn;
      end
      shifted_s = {mant, 32'd0} >> shamt_s;
      mag       = shifted_s[55:24];
      guard     = shifted_s[23];
      sticky    = |shifted_s[22:0];
    end else begin
      sticky = (expn != 8'd0);
    end
  end

endmodule

// File: rtl/ftoi.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter with
// elaboration-time rounding mode and saturation on out-of-range operands.
module ftoi
  import fpu_pkg::*;
#(
  parameter int ROUND_MODE = 0
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_f,
  input  logic        input_valid,
  output logic [31:0] out_i,
  output logic        out_valid,
  output logic        out_invalid
);

  fp32_t op_s;
  assign op_s = in_f;

  logic                s1_valid_r;
  logic                s1_sign_r;
  logic [FP_EXP_W-1:0] s1_exp_r;
  logic [23:0]         s1_mant_r;
  fp_class_t           s1_cls_r;

  // S1: unpack and classify
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= 8'd0;
      s1_mant_r  <= 24'd0;
      s1_cls_r   <= CLS_ZERO;
    end else begin
      s1_valid_r <= input_valid;
      s1_sign_r  <= op_s.sign;
      s1_exp_r   <= op_s.exp;
      s1_mant_r  <= {(op_s.exp != 8'd0), op_s.frac};
      s1_cls_r   <= fp_classify(op_s);
    end
  end

  logic [31:0] align_mag_s;
  logic        align_guard_s;
  logic        align_sticky_s;

  ftoi_align u_align (
    .mant   (s1_mant_r),
    .expn   (s1_exp_r),
    .mag    (align_mag_s),
    .guard  (align_guard_s),
    .sticky (align_sticky_s)
  );

  logic        s2_valid_r;
  logic        s2_sign_r;
  logic [31:0] s2_mag_r;
  logic        s2_guard_r;
  logic        s2_sticky_r;
  fp_class_t   s2_cls_r;

  // S2: register the aligned magnitude and rounding bits
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      s2_sign_r   <= 1'b0;
      s2_mag_r    <= 32'd0;
      s2_guard_r  <= 1'b0;
      s2_sticky_r <= 1'b0;
      s2_cls_r    <= CLS_ZERO;
    end else begin
      s2_valid_r  <= s1_valid_r;
      s2_sign_r   <= s1_sign_r;
      s2_mag_r    <= align_mag_s;
      s2_guard_r  <= align_guard_s;
      s2_sticky_r <= align_sticky_s;
      s2_cls_r    <= s1_cls_r;
    end
  end

  logic        inc_s;
  logic [31:0] rounded_s;
  logic [31:0] signed_s;
  logic [31:0] res_s;
  logic        inv_s;

  // S3 combinational: round, apply sign, select by class
  always_comb begin
    inc_s     = 1'b0;
    rounded_s = 32'd0;
    signed_s  = 32'd0;
    res_s     = 32'd0;
    inv_s     = 1'b0;
    if (ROUND_MODE == 0) begin
      inc_s = s2_guard_r & (s2_sticky_r | s2_mag_r[0]);
    end else begin
      inc_s = 1'b0;
    end
    rounded_s = s2_mag_r + {31'd0, inc_s};
    if (s2_sign_r) begin
      signed_s = 32'd0 - rounded_s;
    end else begin
      signed_s = rounded_s;
    end
    case (s2_cls_r)
      CLS_ZERO: begin
        res_s = 32'd0;
        inv_s = 1'b0;
      end
      CLS_NORM: begin
        res_s = signed_s;
        inv_s = 1'b0;
      end
      CLS_SAT_POS: begin
        res_s = INT_MAX;
        inv_s = 1'b1;
      end
      CLS_SAT_NEG: begin
        res_s = INT_MIN;
        inv_s = 1'b1;
      end
      CLS_NAN: begin
        res_s = INT_MAX;
        inv_s = 1'b1;
      end
      default: begin
        res_s = INT_MAX;
        inv_s = 1'b1;
      end
    endcase
  end

  // S3: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_i       <= 32'd0;
      out_valid   <= 1'b0;
      out_invalid <= 1'b0;
    end else begin
      out_i       <= res_s;
      out_valid   <= s2_valid_r;
      out_invalid <= inv_s;
    end
  end

endmodule

// File: tb/tb_ftoi.sv
// Directed and random self-checking bench for ftoi (RNE instance plus an RTZ instance).
module tb_ftoi;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_f;
  logic        input_valid;
  logic [31:0] out_i, out_i_rtz;
  logic        out_valid, out_invalid, out_valid_rtz, out_invalid_rtz;

  int checks = 0;
  int errors = 0;

  localparam int N_RAND = 1000;
  logic [31:0] sf [N_RAND];
  logic        sv [N_RAND];

  always #5 clk = ~clk;

  ftoi #(.ROUND_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_f(in_f), .input_valid(input_valid),
    .out_i(out_i), .out_valid(out_valid), .out_invalid(out_invalid)
  );

  ftoi #(.ROUND_MODE(1)) dut_rtz (
    .clk(clk), .rst(rst), .in_f(in_f), .input_valid(input_valid),
    .out_i(out_i_rtz), .out_valid(out_valid_rtz), .out_invalid(out_invalid_rtz)
  );

  // Exact RNE reference using remainder comparison against one half
  function automatic logic [32:0] model_ftoi(input logic [31:0] f);
    logic s;
    int e, sh;
    longint unsigned m, q, r, half;
    logic [31:0] mag;
    s = f[31];
    e = int'({24'd0, f[30:23]});
    m = {40'd0, 1'b1, f[22:0]};
    if (e == 255) begin
      if (f[22:0] != 23'd0) return {1'b1, 32'h7FFFFFFF};
      return s ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    end
    if (e == 0) return 33'd0;
    if (e >= 158) begin
      if (s && e == 158 && f[22:0] == 23'd0) return {1'b0, 32'h80000000};
      return s ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    end
    if (e >= 150) begin
      q = m << (e - 150);
    end else begin
      sh = 150 - e;
      if (sh >= 26) begin
        q = 64'd0;
      end else begin
        q = m >> sh;
        r = m - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q = q + 64'd1;
      end
    end
    mag = q[31:0];
    return {1'b0, s ? (32'd0 - mag) : mag};
  endfunction

  task automatic run_op(input logic [31:0] f, output logic [31:0] r, output logic inv,
                        output logic vld, output logic [31:0] r_rtz);
    @(negedge clk);
    in_f = f;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    in_f = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    r = out_i;
    inv = out_invalid;
    vld = out_valid;
    r_rtz = out_i_rtz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    input_valid = 1'b1;
    in_f = 32'h3FC00000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_i !== 32'd0) begin errors++; $display("FAIL reset_out_i: got %h expected 00000000", out_i); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL reset_out_invalid: got %b expected 0", out_invalid); end
    @(negedge clk);
    rst = 1'b0;
    input_valid = 1'b0;
    in_f = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_dropped_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_rounding();
    logic [31:0] vec [5] = '{32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h40600000, 32'hBFC00000};
    logic [31:0] rne [5] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'h00000004, 32'hFFFFFFFE};
    logic [31:0] rtz [5] = '{32'h00000001, 32'h00000002, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    logic [31:0] r, rr;
    logic inv, vld;
    for (int i = 0; i < 5; i++) begin
      run_op(vec[i], r, inv, vld, rr);
      checks++; if (vld !== 1'b1) begin errors++; $display("FAIL round_valid[%h]: got %b expected 1", vec[i], vld); end
      checks++; if (r !== rne[i]) begin errors++; $display("FAIL round_rne[%h]: got %h expected %h", vec[i], r, rne[i]); end
      checks++; if (rr !== rtz[i]) begin errors++; $display("FAIL round_rtz[%h]: got %h expected %h", vec[i], rr, rtz[i]); end
      checks++; if (inv !== 1'b0) begin errors++; $display("FAIL round_invalid[%h]: got %b expected 0", vec[i], inv); end
    end
  endtask

  task automatic test_small();
    logic [31:0] vec [7] = '{32'h3F000000, 32'h3F400000, 32'hBF000000, 32'h00000001,
                             32'h80000000, 32'h3F7FFFFF, 32'hBF400000};
    logic [31:0] exp_v [7] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF};
    logic [31:0] r, rr;
    logic inv, vld;
    for (int i = 0; i < 7; i++) begin
      run_op(vec[i], r, inv, vld, rr);
      checks++; if (r !== exp_v[i]) begin errors++; $display("FAIL small[%h]: got %h expected %h", vec[i], r, exp_v[i]); end
      checks++; if (inv !== 1'b0) begin errors++; $display("FAIL small_invalid[%h]: got %b expected 0", vec[i], inv); end
    end
  endtask

  task automatic test_range();
    logic [31:0] vec [6] = '{32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001,
                             32'h4B000001, 32'hCEFFFFFF};
    logic [31:0] exp_v [6] = '{32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                               32'h00800001, 32'h80000080};
    logic exp_inv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] r, rr;
    logic inv, vld;
    for (int i = 0; i < 6; i++) begin
      run_op(vec[i], r, inv, vld, rr);
      checks++; if (r !== exp_v[i]) begin errors++; $display("FAIL range[%h]: got %h expected %h", vec[i], r, exp_v[i]); end
      checks++; if (inv !== exp_inv[i]) begin errors++; $display("FAIL range_invalid[%h]: got %b expected %b", vec[i], inv, exp_inv[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] vec [4] = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'hFF800001};
    logic [31:0] exp_v [4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] r, rr;
    logic inv, vld;
    for (int i = 0; i < 4; i++) begin
      run_op(vec[i], r, inv, vld, rr);
      checks++; if (r !== exp_v[i]) begin errors++; $display("FAIL special[%h]: got %h expected %h", vec[i], r, exp_v[i]); end
      checks++; if (inv !== 1'b1) begin errors++; $display("FAIL special_invalid[%h]: got %b expected 1", vec[i], inv); end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0]  e8;
    logic [22:0] fr;
    logic [32:0] expv;
    int k;
    for (int i = 0; i < N_RAND; i++) begin
      case ($urandom_range(0, 9))
        7: e8 = 8'd0;
        8: e8 = 8'd255;
        9: e8 = 8'($urandom);
        default: e8 = 8'($urandom_range(120, 160));
      endcase
      fr = 23'($urandom);
      if ($urandom_range(0, 3) == 0) fr = fr & 23'h7FF000;
      sf[i] = {1'($urandom_range(0, 1)), e8, fr};
      sv[i] = ($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < N_RAND + 2; c++) begin
      @(negedge clk);
      if (c < N_RAND) begin
        in_f = sf[c];
        input_valid = sv[c];
      end else begin
        in_f = 32'd0;
        input_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c >= 2) begin
        k = c - 2;
        checks++;
        if (out_valid !== sv[k]) begin
          errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, out_valid, sv[k]);
        end
        if (sv[k]) begin
          expv = model_ftoi(sf[k]);
          checks++;
          if ({out_invalid, out_i} !== expv) begin
            errors++;
            $display("FAIL stream_data[%0d] in=%h: got inv=%b out=%h expected inv=%b out=%h",
                     k, sf[k], out_invalid, out_i, expv[32], expv[31:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); in_f = 32'h3FC00000; input_valid = 1'b1;
    @(negedge clk); in_f = 32'hFF800000;
    @(negedge clk); in_f = 32'h40200000; rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_i !== 32'd0) begin errors++; $display("FAIL mid_reset_out_i: got %h expected 00000000", out_i); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL mid_reset_invalid: got %b expected 0", out_invalid); end
    @(negedge clk); rst = 1'b0; in_f = 32'h41200000; input_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard1: got valid %b expected 0", out_valid); end
    @(negedge clk); input_valid = 1'b0; in_f = 32'd0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard2: got valid %b expected 0", out_valid); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_first_valid: got %b expected 1", out_valid); end
    checks++; if (out_i !== 32'h0000000A) begin errors++; $display("FAIL mid_first_data: got %h expected 0000000a", out_i); end
    checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL mid_first_invalid: got %b expected 0", out_invalid); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    input_valid = 1'b0;
    in_f = 32'd0;
    test_reset();
    test_rounding();
    test_small();
    test_range();
    test_specials();
    test_random_stream();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
